// File: rtl/ca_code_sequencer.sv
// ca_code_sequencer: sequences one C/A code generator for a single channel.
// It accepts PRN and code-phase commands, resets the generator, slews it to
// the requested chip offset at full clock rate, then advances it on code-NCO
// strobes. It keeps the authoritative chip index, epoch pulse and ms count.
// Optional feature macro: CA_SEQ_DWELL_EN (adds a dwell timer that ends
// TRACK after DWELL_MS epochs and pulses dwell_done).
`timescale 1ns/1ps

module ca_code_sequencer #(
  parameter int CODE_LEN   = 1023,
  parameter int MS_PER_BIT = 20,
  parameter int MAX_PRN    = 32
`ifdef CA_SEQ_DWELL_EN
  , parameter int DWELL_MS = 10
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [5:0] cmd_prn,
  input  logic [9:0] cmd_phase,
  input  logic       cmd_abort,
  input  logic       chip_stb,
  output logic       cmd_err,
  output logic       gen_rst,
  output logic       gen_ce,
  output logic [5:0] gen_prn,
  output logic [9:0] chip_idx,
  output logic       epoch,
  output logic [4:0] ms_cnt,
  output logic       tracking,
  output logic       dwell_done
);

  localparam logic [9:0] LAST_CHIP = 10'(CODE_LEN - 1);
  localparam logic [4:0] LAST_MS   = 5'(MS_PER_BIT - 1);
  localparam logic [5:0] PRN_MAX   = 6'(MAX_PRN);

  typedef enum logic [1:0] {IDLE, LOAD, SLEW, TRACK} state_t;

  state_t     state, state_nxt;
  logic [9:0] phase_q;
  logic [9:0] remaining;
  logic       cmd_xfer;
  logic       cmd_bad;
  logic       cmd_ok;
  logic       wrap;

  // Abort blocks the handshake so an aborted cycle can never also transfer.
  assign cmd_ready = ((state == IDLE) || (state == TRACK)) && !cmd_abort;
  assign cmd_xfer  = cmd_valid && cmd_ready;
  assign cmd_bad   = (cmd_prn == 6'd0) || (cmd_prn > PRN_MAX) || (cmd_phase > LAST_CHIP);
  assign cmd_ok    = cmd_xfer && !cmd_bad;
  assign wrap      = gen_ce && (chip_idx == LAST_CHIP);
  assign tracking  = (state == TRACK);

`ifdef CA_SEQ_DWELL_EN
  localparam logic [7:0] LAST_DWELL = 8'(DWELL_MS - 1);
  logic [7:0] dwell_cnt;
`endif

  // Next-state and generator shift enable; abort overrides everything.
  always_comb begin
    state_nxt = state;
    gen_ce    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ok) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = (phase_q != 10'd0) ? SLEW : TRACK;
      end
      SLEW: begin
        gen_ce = 1'b1;
        if (remaining == 10'd1) state_nxt = TRACK;
      end
      TRACK: begin
        if (cmd_ok) begin
          state_nxt = LOAD;
        end else begin
          gen_ce = chip_stb;
`ifdef CA_SEQ_DWELL_EN
          if (chip_stb && (chip_idx == LAST_CHIP) && (dwell_cnt == LAST_DWELL))
            state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (cmd_abort) begin
      state_nxt = IDLE;
      gen_ce    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Command latching, reject pulse and registered generator reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_rst <= 1'b1;
      cmd_err <= 1'b0;
      gen_prn <= 6'd1;
      phase_q <= 10'd0;
    end else begin
      gen_rst <= (state_nxt == IDLE) || (state_nxt == LOAD);
      cmd_err <= cmd_xfer && cmd_bad;
      if (cmd_ok) begin
        gen_prn <= cmd_prn;
        phase_q <= cmd_phase;
      end
    end
  end

  // Chip index, slew countdown, epoch pulse and ms-within-bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= 10'd0;
      chip_idx  <= 10'd0;
      epoch     <= 1'b0;
      ms_cnt    <= 5'd0;
    end else begin
      epoch <= wrap;
      if (cmd_abort)           remaining <= 10'd0;
      else if (state == LOAD)  remaining <= phase_q;
      else if (state == SLEW)  remaining <= remaining - 10'd1;
      if (state == LOAD) begin
        chip_idx <= 10'd0;
        ms_cnt   <= 5'd0;
      end else if (gen_ce) begin
        if (wrap) begin
          chip_idx <= 10'd0;
          ms_cnt   <= (ms_cnt == LAST_MS) ? 5'd0 : ms_cnt + 5'd1;
        end else begin
          chip_idx <= chip_idx + 10'd1;
        end
      end
    end
  end

`ifdef CA_SEQ_DWELL_EN
  // Dwell timer: counts TRACK epochs and flags the last one of the dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt  <= 8'd0;
      dwell_done <= 1'b0;
    end else begin
      dwell_done <= wrap && (dwell_cnt == LAST_DWELL);
      if (state == LOAD)  dwell_cnt <= 8'd0;
      else if (wrap)      dwell_cnt <= dwell_cnt + 8'd1;
    end
  end
`else
  assign dwell_done = 1'b0;
`endif

endmodule
